// File: rtl/ram_bank_ctrl.sv
// Banked RAM controller: accepts one read or write request at a time and
// drives a one-hot strobe to the selected bank, returning read data after RD_LAT cycles.
module ram_bank_ctrl #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int BANK_BITS = 2,
   parameter int RD_LAT    = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic                               req_we,
   input  logic [ADDR_W-1:0]                  req_addr,
   input  logic [DATA_W-1:0]                  req_wdata,
   output logic                               rsp_valid,
   output logic [DATA_W-1:0]                  rsp_rdata,
   output logic [(2**BANK_BITS)-1:0]          bank_we,
   output logic [(2**BANK_BITS)-1:0]          bank_re,
   output logic [ADDR_W-BANK_BITS-1:0]        bank_addr,
   output logic [DATA_W-1:0]                  bank_wdata,
   input  logic [(2**BANK_BITS)*DATA_W-1:0]   bank_rdata
);

   localparam int NUM_BANKS = 2**BANK_BITS;
   localparam int LOW_W     = ADDR_W - BANK_BITS;
   localparam int CNT_W     = 3;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

   typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

   state_t                 state;
   state_t                 next_state;
   logic [BANK_BITS-1:0]   bank_sel;
   logic [BANK_BITS-1:0]   next_bank;
   logic [NUM_BANKS-1:0]   next_strobe;
   logic [CNT_W-1:0]       lat_cnt;
   logic                   accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // next_bank tracks the bank the strobe will target in the coming cycle
   always_comb begin
      next_state  = state;
      accept      = 1'b0;
      next_bank   = bank_sel;
      next_strobe = '0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept     = 1'b1;
               next_bank  = req_addr[ADDR_W-1 -: BANK_BITS];
               next_state = req_we ? WRITE : READ;
            end
         end
         WRITE:   next_state = IDLE;
         READ:    next_state = WAIT;
         WAIT: begin
            if (lat_cnt == '0) begin
               next_state = RESP;
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      next_strobe[next_bank] = 1'b1;
   end

   // every output is registered from next_state so it lines up with the state it belongs to
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         bank_we    <= '0;
         bank_re    <= '0;
         bank_addr  <= '0;
         bank_wdata <= '0;
         bank_sel   <= '0;
         lat_cnt    <= '0;
      end else begin
         req_ready <= (next_state == IDLE);
         rsp_valid <= (next_state == RESP);
         bank_we   <= (next_state == WRITE) ? next_strobe : '0;
         bank_re   <= (next_state == READ)  ? next_strobe : '0;
         if (accept) begin
            bank_sel   <= next_bank;
            bank_addr  <= req_addr[LOW_W-1:0];
            bank_wdata <= req_wdata;
         end
         if (state == READ) begin
            lat_cnt <= LAT_LOAD;
         end else if ((state == WAIT) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
         if ((state == WAIT) && (lat_cnt == '0)) begin
            rsp_rdata <= bank_rdata[int'(bank_sel)*DATA_W +: DATA_W];
         end
      end
   end

endmodule
